timer_sequencer: RTL

Arbitrating controller for the single shared countdown timer and its time-parameter selector in the anti-theft design. Up to `N_REQ` requesters each ask for a timed interval by raising a level request with a 2-bit interval code. The block grants one requester at a time in round-robin order and drives `interval` toward `time_parameters`. It then fires `start_timer` toward `timer`, waits for `expired`, and returns a one-cycle `done` to the owner. It sits between the alarm FSM and any future timed function, such as door-chime or headlight delay, and `timer`/`time_parameters`.

---
 rtl/anti_theft_pkg.sv | 19 +
 rtl/timer_sequencer_rr_arbiter.sv | 30 +++
 rtl/timer_sequencer.sv | 127 ++++++++++++
 3 files changed

// File: rtl/anti_theft_pkg.sv
// Shared types and constants for the anti-theft controller slice:
// timer sequencer state encoding and interval select codes.
package anti_theft_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOAD,
        RUN,
        DONE
    } ts_state_t;

    // Interval select codes understood by time_parameters
    localparam logic [1:0] INT_ARM      = 2'd0;
    localparam logic [1:0] INT_DRV_DLY  = 2'd1;
    localparam logic [1:0] INT_PASS_DLY = 2'd2;
    localparam logic [1:0] INT_ALARM    = 2'd3;

endpackage

// File: rtl/timer_sequencer_rr_arbiter.sv
// Round-robin next-owner pick: scans requesters starting one past the
// previous owner and returns the first active one.
module rr_arbiter
    import anti_theft_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned OWN_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OWN_W-1:0] last_owner,
    output logic             valid,
    output logic [OWN_W-1:0] index
);

    logic [OWN_W-1:0] cand;

    always_comb begin
        valid = 1'b0;
        index = '0;
        cand  = '0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = OWN_W'((32'(last_owner) + i) % N_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/timer_sequencer.sv
// Arbitrates the shared countdown timer among requesters: grants one owner,
// selects its interval, strobes the timer load and returns a done pulse.
module timer_sequencer
    import anti_theft_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned OWN_W = 2
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [2*N_REQ-1:0]   req_interval,
    input  logic                 reprogram,
    input  logic                 expired,
    output logic [1:0]           interval,
    output logic                 start_timer,
    output logic [N_REQ-1:0]     grant,
    output logic [N_REQ-1:0]     done,
    output logic [OWN_W-1:0]     owner,
    output logic                 busy
);

    ts_state_t        state, next_state;
    logic [OWN_W-1:0] last_owner, next_last;
    logic [OWN_W-1:0] next_owner;
    logic [1:0]       next_interval;
    logic             run_first, next_run_first;
    logic             own_req;
    logic             arb_valid;
    logic [OWN_W-1:0] arb_index;
    logic [1:0]       sel_code;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .OWN_W (OWN_W)
    ) u_arb (
        .req        (req),
        .last_owner (last_owner),
        .valid      (arb_valid),
        .index      (arb_index)
    );

    always_comb begin
        sel_code = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (OWN_W'(i) == arb_index) begin
                sel_code = req_interval[2*i +: 2];
            end
        end
    end

    assign own_req = req[owner];

    always_comb begin
        next_state     = state;
        next_owner     = owner;
        next_interval  = interval;
        next_last      = last_owner;
        next_run_first = 1'b0;
        case (state)
            IDLE: begin
                if (!reprogram && arb_valid) begin
                    next_state    = SETUP;
                    next_owner    = arb_index;
                    next_interval = sel_code;
                end
            end
            SETUP: begin
                if (!own_req) begin
                    next_state = IDLE;
                    next_last  = owner;
                end else begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (!own_req) begin
                    next_state = IDLE;
                    next_last  = owner;
                end else begin
                    next_state     = RUN;
                    next_run_first = 1'b1;
                end
            end
            RUN: begin
                // A dropped request wins over a same-cycle expiry: no done on abort
                if (!own_req) begin
                    next_state = IDLE;
                    next_last  = owner;
                end else if (!run_first && expired) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
                next_last  = owner;
            end
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next-state decode so they line up with the state
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= IDLE;
            owner       <= '0;
            interval    <= '0;
            last_owner  <= OWN_W'(N_REQ - 1);
            run_first   <= 1'b0;
            grant       <= '0;
            done        <= '0;
            start_timer <= 1'b0;
            busy        <= 1'b0;
        end else begin
            state       <= next_state;
            owner       <= next_owner;
            interval    <= next_interval;
            last_owner  <= next_last;
            run_first   <= next_run_first;
            grant       <= (next_state != IDLE) ? (N_REQ'(1) << next_owner) : '0;
            done        <= (next_state == DONE) ? (N_REQ'(1) << next_owner) : '0;
            start_timer <= (next_state == LOAD);
            busy        <= (next_state != IDLE);
        end
    end

endmodule
